// File: rtl/button_debouncer.sv
// Debouncer for already-synchronized push-button/switch inputs.
// A shared sample tick paces per-bit saturating counters; a bit is
// considered pressed once it has been seen high for PULSE_CNT_MAX
// consecutive sample ticks. A registered edge detector turns each new
// press into a single-cycle pulse.

module button_debouncer #(
   parameter int WIDTH          = 1,
   parameter int SAMPLE_CNT_MAX = 62500,
   parameter int PULSE_CNT_MAX  = 200
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] glitchy_signal,
   output logic [WIDTH-1:0] debounced_signal,
   output logic [WIDTH-1:0] press_pulse
);

   localparam int SW = $clog2(SAMPLE_CNT_MAX);
   localparam int CW = $clog2(PULSE_CNT_MAX + 1);

   localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
   localparam logic [CW-1:0] PULSE_FULL  = CW'(PULSE_CNT_MAX);

   logic [SW-1:0]    sample_count;
   logic             sample_tick;
   logic [CW-1:0]    cnt [WIDTH];
   logic [WIDTH-1:0] prev;

   // Free-running sample counter shared by every bit; wraps each period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_count <= '0;
      end else if (sample_count == SAMPLE_LAST) begin
         sample_count <= '0;
      end else begin
         sample_count <= sample_count + SW'(1);
      end
   end

   assign sample_tick = (sample_count == SAMPLE_LAST);

   // Per-bit saturating counters: any low sample restarts qualification,
   // which takes precedence over a coincident tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (!glitchy_signal[i]) begin
               cnt[i] <= '0;
            end else if (sample_tick && (cnt[i] < PULSE_FULL)) begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   // Level output is a pure decode of the counter registers.
   always_comb begin
      debounced_signal = '0;
      for (int i = 0; i < WIDTH; i++) begin
         debounced_signal[i] = (cnt[i] == PULSE_FULL);
      end
   end

   // Remember last cycle's level so new presses can be spotted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev <= '0;
      end else begin
         prev <= debounced_signal;
      end
   end

   assign press_pulse = debounced_signal & ~prev;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed testbench for button_debouncer with WIDTH=2, SAMPLE_CNT_MAX=4,
// PULSE_CNT_MAX=3. Edge n is the nth rising clk after reset release;
// sample ticks land on edges 4, 8, 12, ...

module tb_button_debouncer;

   logic       clk;
   logic       rst;
   logic [1:0] glitchy_signal;
   logic [1:0] debounced_signal;
   logic [1:0] press_pulse;

   int check_count;
   int pass_count;
   int fail_count;
   int edge_n;

   button_debouncer #(
      .WIDTH          (2),
      .SAMPLE_CNT_MAX (4),
      .PULSE_CNT_MAX  (3)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .glitchy_signal   (glitchy_signal),
      .debounced_signal (debounced_signal),
      .press_pulse      (press_pulse)
   );

   // 10-unit clock period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at edge %0d", edge_n);
      $fatal(1, "[TB] watchdog");
   end

   task automatic applyStimulus(input logic [1:0] value);
      glitchy_signal = value;
   endtask

   task automatic checkOutput(input string tag, input logic [1:0] exp_deb,
                              input logic [1:0] exp_pulse);
      check_count++;
      assert (debounced_signal === exp_deb) pass_count++;
      else begin
         fail_count++;
         $error("[TB] FAIL %s debounced got %b expected %b", tag, debounced_signal, exp_deb);
      end
      check_count++;
      assert (press_pulse === exp_pulse) pass_count++;
      else begin
         fail_count++;
         $error("[TB] FAIL %s pulse got %b expected %b", tag, press_pulse, exp_pulse);
      end
   endtask

   // Advance to just after edge n (bounded by n itself).
   task automatic waitToEdge(input int n);
      while (edge_n < n) begin
         @(posedge clk);
         #1;
         edge_n++;
      end
   endtask

   // Hold reset while the inputs wiggle, then release on a falling edge.
   task automatic doReset();
      rst = 1'b1;
      applyStimulus(2'b00);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         applyStimulus(2'(i + 1));
         checkOutput("reset_hold", 2'b00, 2'b00);
      end
      @(negedge clk);
      applyStimulus(2'b00);
      rst = 1'b0;
      edge_n = 0;
   endtask

   initial begin
      check_count = 0;
      pass_count  = 0;
      fail_count  = 0;
      edge_n      = 0;
      rst         = 1'b1;
      glitchy_signal = 2'b00;
      #2;
      checkOutput("reset_initial", 2'b00, 2'b00);

      // Clean press on bit 0, then long hold and release
      doReset();
      applyStimulus(2'b01);
      waitToEdge(8);
      checkOutput("clean_e8", 2'b00, 2'b00);
      waitToEdge(11);
      checkOutput("clean_e11", 2'b00, 2'b00);
      waitToEdge(12);
      checkOutput("clean_e12", 2'b01, 2'b01);
      waitToEdge(13);
      checkOutput("clean_e13", 2'b01, 2'b00);
      for (int n = 14; n <= 52; n += 6) begin
         waitToEdge(n);
         checkOutput("hold", 2'b01, 2'b00);
      end
      waitToEdge(59);
      checkOutput("hold_e59", 2'b01, 2'b00);
      applyStimulus(2'b00);
      waitToEdge(60);
      checkOutput("release_e60", 2'b00, 2'b00);
      waitToEdge(61);
      checkOutput("release_e61", 2'b00, 2'b00);

      // Bounce: bit 0 sampled low at edge 10
      doReset();
      applyStimulus(2'b01);
      waitToEdge(9);
      applyStimulus(2'b00);
      waitToEdge(10);
      applyStimulus(2'b01);
      waitToEdge(12);
      checkOutput("bounce_e12", 2'b00, 2'b00);
      waitToEdge(19);
      checkOutput("bounce_e19", 2'b00, 2'b00);
      waitToEdge(20);
      checkOutput("bounce_e20", 2'b01, 2'b01);
      waitToEdge(21);
      checkOutput("bounce_e21", 2'b01, 2'b00);
      waitToEdge(30);
      checkOutput("bounce_e30", 2'b01, 2'b00);

      // Two bits pressed together
      doReset();
      applyStimulus(2'b11);
      waitToEdge(11);
      checkOutput("both_e11", 2'b00, 2'b00);
      waitToEdge(12);
      checkOutput("both_e12", 2'b11, 2'b11);
      waitToEdge(13);
      checkOutput("both_e13", 2'b11, 2'b00);

      // Two bits, bit 1 sampled low at edge 6
      doReset();
      applyStimulus(2'b11);
      waitToEdge(5);
      applyStimulus(2'b01);
      waitToEdge(6);
      applyStimulus(2'b11);
      waitToEdge(12);
      checkOutput("split_e12", 2'b01, 2'b01);
      waitToEdge(13);
      checkOutput("split_e13", 2'b01, 2'b00);
      waitToEdge(15);
      checkOutput("split_e15", 2'b01, 2'b00);
      waitToEdge(16);
      checkOutput("split_e16", 2'b11, 2'b10);
      waitToEdge(17);
      checkOutput("split_e17", 2'b11, 2'b00);

      // Reset mid-operation with button still held
      doReset();
      applyStimulus(2'b01);
      waitToEdge(12);
      checkOutput("midrst_e12", 2'b01, 2'b01);
      waitToEdge(29);
      checkOutput("midrst_e29", 2'b01, 2'b00);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midrst_async", 2'b00, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      edge_n = 0;
      waitToEdge(11);
      checkOutput("requal_e11", 2'b00, 2'b00);
      waitToEdge(12);
      checkOutput("requal_e12", 2'b01, 2'b01);
      waitToEdge(13);
      checkOutput("requal_e13", 2'b01, 2'b00);

      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions synchronized push-button/switch inputs into clean levels plus one-cycle press pulses.
- Sits directly downstream of the 2-flop synchronizer and consumes its sync_signal output.
- Uses a shared sample-tick counter and per-bit saturating counters.
- The level output asserts only after the input stays high for a programmed number of sample ticks.
- A registered rising-edge detector produces the press pulse consumed by the CPU IO/MMIO logic.

Parameters:
- WIDTH, 1, number of independent input bits.
- SAMPLE_CNT_MAX, 62500, clock cycles per sample tick. Must be >= 2.
- PULSE_CNT_MAX, 200, consecutive high sample ticks needed to declare a bit pressed. Must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- glitchy_signal  input  WIDTH  synchronized but bouncy inputs, one per bit.
- debounced_signal  output  WIDTH  clean level per bit.
- press_pulse  output  WIDTH  one-cycle pulse on each 0->1 transition of debounced_signal.

Behaviour:
- Clock and reset:
  - One clock domain.
  - rst is asynchronous and active-high: all state clears immediately on assertion, regardless of clk.
- Reset values: sample counter = 0, every per-bit counter = 0, every prev register = 0, debounced_signal = 0, press_pulse = 0.
- Sample counter:
  - Width clog2(SAMPLE_CNT_MAX).
  - Counts 0..SAMPLE_CNT_MAX-1 and wraps to 0.
  - Runs continuously after reset, independent of the inputs.
  - sample_tick is combinational and high while count == SAMPLE_CNT_MAX-1 (one cycle per period).
- Per-bit saturating counter cnt[i]:
  - Width clog2(PULSE_CNT_MAX+1).
  - At each clk edge, priority order:
    1. glitchy_signal[i]==0: cnt[i] <= 0. This overrides a tick.
    2. Else if sample_tick and cnt[i] < PULSE_CNT_MAX: cnt[i] <= cnt[i]+1.
    3. Else hold.
  - Never exceeds PULSE_CNT_MAX and never wraps.
- debounced_signal[i] = (cnt[i] == PULSE_CNT_MAX), decoded combinationally from the register so it cannot glitch.
- Edge detect:
  - prev[i] <= debounced_signal[i] every edge.
  - press_pulse[i] = debounced_signal[i] & ~prev[i].
  - Exactly one cycle high per assertion of debounced_signal[i].
  - No pulse on release.
- Assert latency: from the first high sample to debounced high is between (PULSE_CNT_MAX-1)*SAMPLE_CNT_MAX+1 and PULSE_CNT_MAX*SAMPLE_CNT_MAX cycles, depending on tick phase.
- Release latency: one low sample clears cnt[i]. debounced_signal[i] falls in the cycle after the first edge at which the input is sampled low.
- Bit independence: all bits share the tick but otherwise do not interact. Simultaneous presses each give their own pulse in the same cycle.
- Held input: stays saturated. debounced remains 1 and press_pulse remains 0 indefinitely.
- Reset mid-operation: counters and outputs clear at once. A still-held button must requalify for the full count, then produces a fresh press_pulse.

Test Plan:
(Bench parameters: WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3. Edge n = nth rising clk after rst deassertion; sample counter = n mod 4; ticks increment at edges 4, 8, 12, ...)
1. Reset: hold rst high and toggle glitchy_signal -> debounced_signal=00 and press_pulse=00 throughout; rst asserted mid-cycle clears outputs without waiting for clk.
2. Clean press: glitchy_signal[0]=1 from edge 1 on -> cnt[0] = 1/2/3 after edges 4/8/12; debounced_signal[0]=1 after edge 12; press_pulse[0]=1 only between edges 12 and 13; bit 1 stays 0.
3. Bounce: bit 0 high from edge 1 but sampled low at edge 10 -> cnt clears at edge 10; debounced_signal[0] rises after edge 20, not 12; exactly one press_pulse.
4. Release and hold: after case 2, keep the input high 40 more cycles -> no further pulses. Drop the input at edge 60 -> debounced_signal[0]=0 after edge 60; no pulse on release.
5. Two bits: glitchy_signal=11 from edge 1 -> both debounced after edge 12 and press_pulse=11 for one cycle. Bit 1 low at edge 6 -> only bit 1 delayed, rising after edge 16.
6. Reset mid-operation: bit 0 debounced high, pulse rst at edge 30 with input still high -> outputs 0 immediately; debounced rises again 12 edges after rst release with a new press_pulse.
